// File: rtl/kb_ascii_fifo.sv
// Translates PS/2 make codes to ASCII and buffers them in a first-word-fall-through FIFO.
// Unmapped codes are discarded; a character dropped on a full FIFO sets a sticky overflow flag.
module kb_ascii_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [7:0]            scan_code,
  input  logic                  scan_code_ready,
  input  logic                  letter_case,
  input  logic                  rd_en,
  input  logic                  clr_overflow,
  output logic [7:0]            ascii_out,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_ONE = 1;
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [7:0]            raw_ascii;
  logic                  mapped;
  logic [7:0]            xl_ascii;
  logic                  s1_valid;
  logic [7:0]            s1_data;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  pop;
  logic                  push_ok;
  logic                  drop;

  // Table yields the lowercase form; only the 'a'..'z' range is case-shifted.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    raw_ascii = 8'h00;
    mapped    = 1'b1;
    case (scan_code)
      8'h1C: raw_ascii = 8'h61;  8'h32: raw_ascii = 8'h62;  8'h21: raw_ascii = 8'h63;
      8'h23: raw_ascii = 8'h64;  8'h24: raw_ascii = 8'h65;  8'h2B: raw_ascii = 8'h66;
      8'h34: raw_ascii = 8'h67;  8'h33: raw_ascii = 8'h68;  8'h43: raw_ascii = 8'h69;
      8'h3B: raw_ascii = 8'h6A;  8'h42: raw_ascii = 8'h6B;  8'h4B: raw_ascii = 8'h6C;
      8'h3A: raw_ascii = 8'h6D;  8'h31: raw_ascii = 8'h6E;  8'h44: raw_ascii = 8'h6F;
      8'h4D: raw_ascii = 8'h70;  8'h15: raw_ascii = 8'h71;  8'h2D: raw_ascii = 8'h72;
      8'h1B: raw_ascii = 8'h73;  8'h2C: raw_ascii = 8'h74;  8'h3C: raw_ascii = 8'h75;
      8'h2A: raw_ascii = 8'h76;  8'h1D: raw_ascii = 8'h77;  8'h22: raw_ascii = 8'h78;
      8'h35: raw_ascii = 8'h79;  8'h1A: raw_ascii = 8'h7A;
      8'h45: raw_ascii = 8'h30;  8'h16: raw_ascii = 8'h31;  8'h1E: raw_ascii = 8'h32;
      8'h26: raw_ascii = 8'h33;  8'h25: raw_ascii = 8'h34;  8'h2E: raw_ascii = 8'h35;
      8'h36: raw_ascii = 8'h36;  8'h3D: raw_ascii = 8'h37;  8'h3E: raw_ascii = 8'h38;
      8'h46: raw_ascii = 8'h39;
      8'h29: raw_ascii = 8'h20;  8'h5A: raw_ascii = 8'h0D;  8'h66: raw_ascii = 8'h08;
      default: mapped = 1'b0;
    endcase
    xl_ascii = raw_ascii;
    if (letter_case && raw_ascii >= 8'h61 && raw_ascii <= 8'h7A)
      xl_ascii = raw_ascii - 8'h20;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_valid <= 1'b0;
      s1_data  <= 8'h00;
    end else begin
      s1_valid <= scan_code_ready && mapped;
      s1_data  <= xl_ascii;
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign pop     = rd_en && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still succeeds.
  assign push_ok = s1_valid && (!full || pop);
  assign drop    = s1_valid && full && !pop;

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= s1_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      if (push_ok && !pop)      count <= count + CNT_ONE;
      else if (pop && !push_ok) count <= count - CNT_ONE;
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign ascii_out = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_kb_ascii_fifo.sv
// Self-checking bench for kb_ascii_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based model of the keyboard-to-ASCII buffer.
module tb_kb_ascii_fifo;

  localparam int DEPTH_LOG2 = 4;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic                clk = 1'b0;
  logic                reset_n;
  logic [7:0]          scan_code;
  logic                scan_code_ready;
  logic                letter_case;
  logic                rd_en;
  logic                clr_overflow;
  logic [7:0]          ascii_out;
  logic                empty;
  logic                full;
  logic [DEPTH_LOG2:0] count;
  logic                overflow;

  kb_ascii_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
    .clk(clk), .reset_n(reset_n), .scan_code(scan_code),
    .scan_code_ready(scan_code_ready), .letter_case(letter_case),
    .rd_en(rd_en), .clr_overflow(clr_overflow), .ascii_out(ascii_out),
    .empty(empty), .full(full), .count(count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  // Make codes for 'a'..'z' and '0'..'9' in character order.
  logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] q [$];
  logic       pend_v;
  logic [7:0] pend_c;
  logic       m_ovf;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Returns {mapped, ascii}.
  function automatic logic [8:0] xlat(input logic [7:0] c, input logic lc);
    for (int i = 0; i < 26; i++)
      if (c == letter_codes[i]) return {1'b1, (lc ? 8'h41 : 8'h61) + 8'(i)};
    for (int i = 0; i < 10; i++)
      if (c == digit_codes[i]) return {1'b1, 8'h30 + 8'(i)};
    if (c == 8'h29) return {1'b1, 8'h20};
    if (c == 8'h5A) return {1'b1, 8'h0D};
    if (c == 8'h66) return {1'b1, 8'h08};
    return 9'h000;
  endfunction

  task automatic compare_all(input string tag);
    check({tag, ".empty"},    32'(empty),     32'(q.size() == 0));
    check({tag, ".count"},    32'(count),     32'(q.size()));
    check({tag, ".full"},     32'(full),      32'(q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    check({tag, ".ascii"},    32'(ascii_out), (q.size() == 0) ? 32'h0 : 32'(q[0]));
  endtask

  task automatic model_clear();
    q.delete();
    pend_v = 1'b0;
    pend_c = 8'h00;
    m_ovf  = 1'b0;
  endtask

  // Called at negedge: drives one cycle of inputs, advances model at posedge, checks after.
  task automatic step(input string tag, input logic sr, input logic [7:0] sc,
                      input logic lc, input logic rd, input logic clr);
    logic [8:0] t;
    logic       popped;
    logic       dropped;
    scan_code_ready = sr; scan_code = sc; letter_case = lc;
    rd_en = rd; clr_overflow = clr;
    @(posedge clk);
    popped  = rd && (q.size() > 0);
    dropped = 1'b0;
    if (popped) void'(q.pop_front());
    if (pend_v) begin
      if (q.size() < DEPTH) q.push_back(pend_c);
      else dropped = 1'b1;
    end
    if (dropped) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    t = xlat(sc, lc);
    pend_v = sr && t[8];
    pend_c = t[7:0];
    #1 compare_all(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pulse_reset(input string tag);
    scan_code_ready = 1'b0; rd_en = 1'b0; clr_overflow = 1'b0;
    #2 reset_n = 1'b0;
    model_clear();
    #1 compare_all(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [7:0] rand_code();
    int k;
    if ($urandom_range(0, 9) < 7) begin
      k = $urandom_range(0, 38);
      if (k < 26) return letter_codes[k];
      if (k < 36) return digit_codes[k - 26];
      if (k == 36) return 8'h29;
      if (k == 37) return 8'h5A;
      return 8'h66;
    end
    return 8'($urandom);
  endfunction

  initial begin
    scan_code = 8'h00; scan_code_ready = 1'b0; letter_case = 1'b0;
    rd_en = 1'b0; clr_overflow = 1'b0;
    model_clear();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2 compare_all("reset");
    @(negedge clk);
    reset_n = 1'b1;

    // Single lowercase character, two-cycle latency, then pop.
    step("a_strobe", 1'b1, 8'h1C, 1'b0, 1'b0, 1'b0);
    idle("a_wait", 2);
    step("a_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Uppercase letter, digit with case set, enter.
    step("seq1", 1'b1, 8'h1C, 1'b1, 1'b0, 1'b0);
    step("seq2", 1'b1, 8'h16, 1'b1, 1'b0, 1'b0);
    step("seq3", 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    idle("seq_wait", 2);
    for (int i = 0; i < 4; i++) step("seq_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Unmapped codes are discarded.
    step("unm1", 1'b1, 8'h76, 1'b0, 1'b0, 1'b0);
    step("unm2", 1'b1, 8'h12, 1'b1, 1'b0, 1'b0);
    idle("unm_wait", 3);

    // Fill, overflow, clear.
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'h24, 1'b0, 1'b0, 1'b0);
    idle("fill_wait", 2);
    step("ovf_strobe", 1'b1, 8'h24, 1'b0, 1'b0, 1'b0);
    idle("ovf_wait", 2);
    step("ovf_clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Push while full with a simultaneous pop: no overflow, space lands last.
    step("fullrw_strobe", 1'b1, 8'h29, 1'b0, 1'b0, 1'b0);
    step("fullrw_pop", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle("fullrw_wait", 1);
    for (int i = 0; i < DEPTH + 1; i++) step("drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Pop while empty.
    step("pop_empty", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Pointer wrap with interleaved pops.
    for (int i = 0; i < 40; i++)
      step("wrap", 1'b1, letter_codes[$urandom_range(0, 25)], 1'(i % 3 == 0), 1'(i % 2), 1'b0);
    idle("wrap_wait", 2);
    while (q.size() > 0) step("wrap_drain", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

    // Reset with three entries buffered, then one normal strobe.
    step("rst_fill", 1'b1, 8'h45, 1'b0, 1'b0, 1'b0);
    step("rst_fill", 1'b1, 8'h66, 1'b0, 1'b0, 1'b0);
    step("rst_fill", 1'b1, 8'h2B, 1'b1, 1'b0, 1'b0);
    idle("rst_fill_wait", 2);
    pulse_reset("midreset");
    step("post_rst", 1'b1, 8'h1A, 1'b1, 1'b0, 1'b0);
    idle("post_rst_wait", 2);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      step("rand", 1'($urandom_range(0, 9) < 6), rand_code(), 1'($urandom),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 19) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
